// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt sequencer between the commit stage and CP0.
// Picks the highest-priority event on the committing instruction and issues
// one-cycle CP0 update strobes and a pipeline flush. It then hands a redirect
// PC to fetch over a valid/ready handshake.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [6:0]  wb_exc,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic [7:0]  cause_ip,
    input  logic [7:0]  status_im,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ready,
    output logic        wb_kill,
    output logic        busy,
    output logic        exception,
    output logic [4:0]  exc_code,
    output logic        exc_bd,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        badvaddr_we,
    output logic [31:0] badvaddr_data,
    output logic        eret_commit,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t      state;
    logic        int_pend;
    logic        detect;
    logic [4:0]  code_n;
    logic        is_exc_n;
    logic        bv_we_n;
    logic [31:0] bv_n;
    logic [31:0] target_q;

    assign int_pend = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign detect   = (state == IDLE) & wb_valid & (int_pend | (|wb_exc) | wb_eret);
    assign wb_kill  = detect;
    assign busy     = (state != IDLE);

    // Priority select of the event to take; lower-priority flags are dropped.
    always_comb begin
        code_n   = 5'h00;
        is_exc_n = 1'b1;
        bv_we_n  = 1'b0;
        bv_n     = '0;
        if (int_pend) begin
            code_n = 5'h00;
        end else if (wb_exc[0]) begin
            code_n  = 5'h04;
            bv_we_n = 1'b1;
            bv_n    = wb_pc;
        end else if (wb_exc[1]) begin
            code_n = 5'h0a;
        end else if (wb_exc[2]) begin
            code_n = 5'h0c;
        end else if (wb_exc[3]) begin
            code_n = 5'h08;
        end else if (wb_exc[4]) begin
            code_n = 5'h09;
        end else if (wb_exc[5]) begin
            code_n  = 5'h04;
            bv_we_n = 1'b1;
            bv_n    = wb_badvaddr;
        end else if (wb_exc[6]) begin
            code_n  = 5'h05;
            bv_we_n = 1'b1;
            bv_n    = wb_badvaddr;
        end else begin
            is_exc_n = 1'b0;
        end
    end

    // Sequencer FSM with registered strobes; strobes loaded at detect appear in FLUSH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            exception      <= 1'b0;
            exc_code       <= '0;
            exc_bd         <= 1'b0;
            epc_we         <= 1'b0;
            epc_data       <= '0;
            badvaddr_we    <= 1'b0;
            badvaddr_data  <= '0;
            eret_commit    <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            target_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (detect) begin
                        state         <= FLUSH;
                        flush         <= 1'b1;
                        exception     <= is_exc_n;
                        eret_commit   <= ~is_exc_n;
                        exc_code      <= code_n;
                        exc_bd        <= wb_bd;
                        epc_data      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                        epc_we        <= is_exc_n & ~status_exl;
                        badvaddr_we   <= bv_we_n;
                        badvaddr_data <= bv_n;
                        target_q      <= is_exc_n ? EXC_VECTOR : cp0_epc;
                    end
                end
                FLUSH: begin
                    state          <= REDIRECT;
                    flush          <= 1'b0;
                    exception      <= 1'b0;
                    eret_commit    <= 1'b0;
                    epc_we         <= 1'b0;
                    badvaddr_we    <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target_q;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: table of directed events plus
// hand-written sequences for reset, redirect back-pressure and masking.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic [6:0]  wb_exc;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic [7:0]  cause_ip;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic [31:0] cp0_epc;
    logic        redirect_ready;
    logic        wb_kill;
    logic        busy;
    logic        exception;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic        epc_we;
    logic [31:0] epc_data;
    logic        badvaddr_we;
    logic [31:0] badvaddr_data;
    logic        eret_commit;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    cp0_exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_bd(wb_bd), .wb_exc(wb_exc), .wb_badvaddr(wb_badvaddr),
        .wb_eret(wb_eret), .cause_ip(cause_ip), .status_im(status_im),
        .status_ie(status_ie), .status_exl(status_exl), .cp0_epc(cp0_epc),
        .redirect_ready(redirect_ready), .wb_kill(wb_kill), .busy(busy),
        .exception(exception), .exc_code(exc_code), .exc_bd(exc_bd),
        .epc_we(epc_we), .epc_data(epc_data), .badvaddr_we(badvaddr_we),
        .badvaddr_data(badvaddr_data), .eret_commit(eret_commit),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  exc;
        logic        eret;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badv;
        logic [7:0]  ip;
        logic [7:0]  im;
        logic        ie;
        logic        exl;
        logic [31:0] epc_in;
        logic [4:0]  e_code;
        logic        e_epc_we;
        logic [31:0] e_epc;
        logic        e_bv_we;
        logic [31:0] e_bv;
        logic        e_eret;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = '0; wb_bd = 1'b0; wb_exc = '0;
        wb_badvaddr = '0; wb_eret = 1'b0; cause_ip = '0; status_im = '0;
        status_ie = 1'b0; status_exl = 1'b0; cp0_epc = '0;
    endtask

    function automatic vec_t mk(input logic [6:0] exc, input logic eret, input logic bd,
                                input logic [31:0] pc, input logic [31:0] badv,
                                input logic [7:0] ip, input logic [7:0] im,
                                input logic ie, input logic exl, input logic [31:0] epc_in,
                                input logic [4:0] e_code, input logic e_epc_we,
                                input logic [31:0] e_epc, input logic e_bv_we,
                                input logic [31:0] e_bv, input logic e_eret,
                                input logic [31:0] e_rpc);
        vec_t t;
        t.exc = exc; t.eret = eret; t.bd = bd; t.pc = pc; t.badv = badv;
        t.ip = ip; t.im = im; t.ie = ie; t.exl = exl; t.epc_in = epc_in;
        t.e_code = e_code; t.e_epc_we = e_epc_we; t.e_epc = e_epc;
        t.e_bv_we = e_bv_we; t.e_bv = e_bv; t.e_eret = e_eret; t.e_rpc = e_rpc;
        return t;
    endfunction

    task automatic drive_event(input vec_t t);
        wb_valid = 1'b1; wb_exc = t.exc; wb_eret = t.eret; wb_bd = t.bd;
        wb_pc = t.pc; wb_badvaddr = t.badv; cause_ip = t.ip; status_im = t.im;
        status_ie = t.ie; status_exl = t.exl; cp0_epc = t.epc_in;
    endtask

    // Full event: detect, FLUSH strobes, REDIRECT, immediate accept.
    task automatic run_vec(input vec_t t, input int idx);
        @(negedge clk);
        drive_event(t);
        #1 check($sformatf("v%0d_wb_kill", idx), {31'b0, wb_kill}, 32'd1);
        @(negedge clk);
        idle_inputs();
        check($sformatf("v%0d_flush", idx), {31'b0, flush}, 32'd1);
        check($sformatf("v%0d_exception", idx), {31'b0, exception}, {31'b0, ~t.e_eret});
        check($sformatf("v%0d_eret_commit", idx), {31'b0, eret_commit}, {31'b0, t.e_eret});
        if (!t.e_eret)
            check($sformatf("v%0d_exc_code", idx), {27'b0, exc_code}, {27'b0, t.e_code});
        check($sformatf("v%0d_exc_bd", idx), {31'b0, exc_bd}, {31'b0, t.bd});
        check($sformatf("v%0d_epc_we", idx), {31'b0, epc_we}, {31'b0, t.e_epc_we});
        check($sformatf("v%0d_epc_data", idx), epc_data, t.e_epc);
        check($sformatf("v%0d_badvaddr_we", idx), {31'b0, badvaddr_we}, {31'b0, t.e_bv_we});
        if (t.e_bv_we)
            check($sformatf("v%0d_badvaddr_data", idx), badvaddr_data, t.e_bv);
        check($sformatf("v%0d_busy_flush", idx), {31'b0, busy}, 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_redirect_valid", idx), {31'b0, redirect_valid}, 32'd1);
        check($sformatf("v%0d_redirect_pc", idx), redirect_pc, t.e_rpc);
        check($sformatf("v%0d_strobes_off", idx),
              {27'b0, flush, exception, eret_commit, epc_we, badvaddr_we}, 32'd0);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        check($sformatf("v%0d_rv_drop", idx), {31'b0, redirect_valid}, 32'd0);
        check($sformatf("v%0d_idle", idx), {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vec_t t;
        // exc, eret, bd, pc, badv, ip, im, ie, exl, epc_in, | code, epc_we, epc, bv_we, bv, eret, rpc
        vecs[0]  = mk(7'h02, 0, 0, 32'h8000_1000, 32'h0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h0a, 1, 32'h8000_1000, 0, 32'h0, 0, VEC);
        vecs[1]  = mk(7'h40, 0, 1, 32'h8000_0004, 32'h1234_5671, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h05, 1, 32'h8000_0000, 1, 32'h1234_5671, 0, VEC);
        vecs[2]  = mk(7'h02, 0, 0, 32'h8000_3000, 32'h0, 8'h80, 8'h80, 1, 0, 32'h0,
                      5'h00, 1, 32'h8000_3000, 0, 32'h0, 0, VEC);
        vecs[3]  = mk(7'h02, 0, 0, 32'h8000_3000, 32'h0, 8'h80, 8'h80, 1, 1, 32'h0,
                      5'h0a, 0, 32'h8000_3000, 0, 32'h0, 0, VEC);
        vecs[4]  = mk(7'h00, 1, 0, 32'h8000_4000, 32'h0, 8'h00, 8'h00, 0, 1, 32'h8000_2000,
                      5'h00, 0, 32'h8000_4000, 0, 32'h0, 1, 32'h8000_2000);
        vecs[5]  = mk(7'h01, 0, 0, 32'h8000_0003, 32'h5555_0000, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h04, 1, 32'h8000_0003, 1, 32'h8000_0003, 0, VEC);
        vecs[6]  = mk(7'h0c, 0, 0, 32'h8000_0100, 32'h0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h0c, 1, 32'h8000_0100, 0, 32'h0, 0, VEC);
        vecs[7]  = mk(7'h18, 0, 0, 32'h8000_0200, 32'h0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h08, 1, 32'h8000_0200, 0, 32'h0, 0, VEC);
        vecs[8]  = mk(7'h10, 0, 1, 32'h0000_0000, 32'h0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h09, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, VEC);
        vecs[9]  = mk(7'h60, 0, 0, 32'h8000_0300, 32'hDEAD_BEE0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h04, 1, 32'h8000_0300, 1, 32'hDEAD_BEE0, 0, VEC);
        vecs[10] = mk(7'h00, 1, 0, 32'h8000_0400, 32'h0, 8'h01, 8'h01, 1, 0, 32'h8000_2000,
                      5'h00, 1, 32'h8000_0400, 0, 32'h0, 0, VEC);
        vecs[11] = mk(7'h22, 0, 0, 32'h8000_0500, 32'h0000_0FF0, 8'h00, 8'h00, 0, 0, 32'h0,
                      5'h0a, 1, 32'h8000_0500, 0, 32'h0, 0, VEC);

        idle_inputs();
        redirect_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {21'b0, busy, exception, exc_bd, epc_we, badvaddr_we, eret_commit,
               flush, redirect_valid, wb_kill, 2'b0}, 32'd0);
        check("reset_exc_code", {27'b0, exc_code}, 32'd0);
        check("reset_redirect_pc", redirect_pc, 32'd0);
        check("reset_epc_data", epc_data, 32'd0);
        check("reset_badvaddr_data", badvaddr_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Masked interrupt with no flags: no event.
        @(negedge clk);
        wb_valid = 1'b1; status_ie = 1'b1; cause_ip = 8'h01; status_im = 8'h02;
        #1 check("masked_int_kill", {31'b0, wb_kill}, 32'd0);
        @(negedge clk);
        check("masked_int_busy", {31'b0, busy}, 32'd0);
        check("masked_int_flush", {31'b0, flush}, 32'd0);
        idle_inputs();

        // ERET with redirect back-pressure; events while busy must be ignored.
        t = vecs[4];
        @(negedge clk);
        drive_event(t);
        @(negedge clk);
        check("bp_eret_commit", {31'b0, eret_commit}, 32'd1);
        check("bp_exception", {31'b0, exception}, 32'd0);
        wb_eret = 1'b0; wb_exc = 7'h02; status_exl = 1'b0;
        #1 check("bp_kill_in_flush", {31'b0, wb_kill}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp_rv_%0d", k), {31'b0, redirect_valid}, 32'd1);
            check($sformatf("bp_rpc_%0d", k), redirect_pc, 32'h8000_2000);
            check($sformatf("bp_busy_%0d", k), {31'b0, busy}, 32'd1);
            check($sformatf("bp_kill_%0d", k), {31'b0, wb_kill}, 32'd0);
            check($sformatf("bp_strobes_%0d", k),
                  {29'b0, flush, exception, eret_commit}, 32'd0);
        end
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        check("bp_rv_drop", {31'b0, redirect_valid}, 32'd0);
        check("bp_idle", {31'b0, busy}, 32'd0);
        check("bp_no_second_event", {31'b0, flush}, 32'd0);

        // Reset while in REDIRECT.
        @(negedge clk);
        drive_event(vecs[0]);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("rst_pre_rv", {31'b0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rv", {31'b0, redirect_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_strobes", {27'b0, flush, exception, eret_commit, epc_we, badvaddr_we}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_epc", epc_data, 32'd0);
        check("rst_code", {27'b0, exc_code}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_strobe_after", {31'b0, flush}, 32'd0);
        run_vec(vecs[6], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception/interrupt sequencer sitting between the commit (WB) stage and the CP0 register file. Each cycle it picks the highest-priority event on the committing instruction (interrupt, synchronous exception or ERET). It then drives the single-cycle update strobes consumed by Cause/Status/EPC/BadVAddr, flushes the pipeline and hands a redirect PC to fetch with a valid/ready handshake.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- wb_valid  in  1  instruction at commit point is valid
- wb_pc  in  32  PC of committing instruction
- wb_bd  in  1  committing instruction is in a branch delay slot
- wb_exc  in  7  flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-data, [6] AdES-data
- wb_badvaddr  in  32  faulting data address (valid with [5]/[6])
- wb_eret  in  1  committing instruction is ERET
- cause_ip  in  8  Cause.IP[7:0]
- status_im  in  8  Status.IM[7:0]
- status_ie, status_exl  in  1 each  Status.IE, Status.EXL
- cp0_epc  in  32  current EPC value
- redirect_ready  in  1  fetch accepts redirect
- wb_kill  out  1  combinational: suppress commit of current WB instruction
- busy  out  1  controller not IDLE; WB must hold bubbles
- exception  out  1  one-cycle strobe to Cause/Status/EPC
- exc_code  out  5  ExcCode for Cause
- exc_bd  out  1  BD bit for Cause
- epc_we  out  1  write EPC (exception & ~EXL at capture)
- epc_data  out  32  EPC value
- badvaddr_we  out  1  write BadVAddr
- badvaddr_data  out  32  BadVAddr value
- eret_commit  out  1  one-cycle strobe: clear Status.EXL
- flush  out  1  one-cycle pipeline flush
- redirect_valid  out  1  redirect PC valid
- redirect_pc  out  32  target PC

## Operation
- int_pend = status_ie & ~status_exl & |(cause_ip & status_im).
- detect = (state==IDLE) & wb_valid & (int_pend | |wb_exc | wb_eret); wb_kill = detect.
- Priority (high→low): Int(0x00), AdEL-fetch(0x04), RI(0x0a), Ov(0x0c), Sys(0x08), Bp(0x09), AdEL-data(0x04), AdES-data(0x05), ERET. Lower-priority flags are ignored on the same instruction.
- On detect, capture into registers: code, bd=wb_bd, epc = wb_bd ? wb_pc−4 : wb_pc (32-bit wrap), epc_we = ~status_exl. Also capture badvaddr: wb_pc for AdEL-fetch, wb_badvaddr for data AdEL/AdES; badvaddr_we is 0 for all other codes. Capture kind (exc/eret) and target: EXC_VECTOR for exceptions, cp0_epc sampled at detect for ERET.
- FSM: IDLE → FLUSH on detect; FLUSH → REDIRECT unconditionally; REDIRECT → IDLE when redirect_valid & redirect_ready.
- FLUSH: flush=1; exception=1 (exc kind) or eret_commit=1 (eret kind); exc_code/exc_bd/epc_*/badvaddr_* driven from capture registers. All write strobes are 0 outside FLUSH.
- REDIRECT: redirect_valid=1, redirect_pc stable until accepted. redirect_ready outside REDIRECT is ignored.
- busy = state≠IDLE. wb_valid is ignored while busy, so a second event cannot be captured.
- ERET with int_pend: the interrupt wins (EPC = ERET PC).

## Timing
- Reset values: state IDLE; all outputs 0 (exc_code 0, redirect_pc 0, epc_data 0, badvaddr_data 0).
- Reset asserted in any state returns to IDLE next edge and drops redirect_valid; no strobe is issued.
- Cycle T detect (wb_kill high). T+1 FLUSH strobes. T+2 redirect_valid rises. Handshake at cycle H → IDLE at H+1; new detect is possible at H+1. Minimum event-to-event spacing is 3 cycles.
- Strobes are exactly one cycle wide regardless of redirect_ready.

## Test plan
- wb_valid, wb_exc=7'b0000010, wb_pc=0x8000_1000, wb_bd=0, EXL=0 → T+1: exception=1, exc_code=0x0a, epc_we=1, epc_data=0x8000_1000, flush=1; T+2: redirect_pc=0xBFC0_0380.
- AdES-data with wb_bd=1, wb_pc=0x8000_0004, wb_badvaddr=0x1234_5671 → exc_code=0x05, exc_bd=1, epc_data=0x8000_0000, badvaddr_we=1, badvaddr_data=0x1234_5671.
- IE=1, EXL=0, cause_ip=0x80, status_im=0x80, wb_exc=RI → exc_code=0x00 (Int wins); with status_exl=1 → RI taken, epc_we=0.
- wb_eret, cp0_epc=0x8000_2000, no int → eret_commit=1 at T+1, exception=0; redirect_pc=0x8000_2000; redirect_ready held low 4 cycles → redirect_valid stays high and stable, busy=1, wb events ignored.
- rst_n low during REDIRECT → next cycle all outputs 0, state IDLE; a new detect is accepted one cycle after release.
- AdEL-fetch with wb_pc=0x8000_0003 → exc_code=0x04, badvaddr_data=0x8000_0003.
